ram_arbiter: RTL and testbench

- Two-requester controller that shares one single-port ram instance (combinational read, write on clk edge when st is high) between two clients.
- Round-robin arbitration, one access in flight at a time, req/ack handshake per client.
- Read data is registered back to the winning client.
- Sits between the ram and two independent masters, for example a CPU data port and a DMA/loader port.

---
 rtl/ram_arbiter_if.sv | 53 +++++
 rtl/ram_arbiter.sv | 133 +++++++++++++
 tb/tb_ram_arbiter.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter_if
// Description : Bundle of the two client handshakes and the ram-side bus of
//               ram_arbiter.
//               slave  - arbiter view: client requests and ram read data in,
//                        client acks/read data and ram controls out.
//               master - environment view (clients + ram): the reverse.
//               Client N: reqN/weN/adN/XN in, ackN/ON out.
//               Ram     : mem_ad/mem_st/mem_X out, mem_O in.  busy out.
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_arbiter_if #(
  parameter int BUS_WIDTH     = 8,
  parameter int ADDRESS_WIDTH = 8
);
  logic                     req0;
  logic                     we0;
  logic [ADDRESS_WIDTH-1:0] ad0;
  logic [BUS_WIDTH-1:0]     X0;
  logic                     ack0;
  logic [BUS_WIDTH-1:0]     O0;

  logic                     req1;
  logic                     we1;
  logic [ADDRESS_WIDTH-1:0] ad1;
  logic [BUS_WIDTH-1:0]     X1;
  logic                     ack1;
  logic [BUS_WIDTH-1:0]     O1;

  logic [ADDRESS_WIDTH-1:0] mem_ad;
  logic                     mem_st;
  logic [BUS_WIDTH-1:0]     mem_X;
  logic [BUS_WIDTH-1:0]     mem_O;
  logic                     busy;

  modport slave (
    input  req0, we0, ad0, X0,
    input  req1, we1, ad1, X1,
    input  mem_O,
    output ack0, O0, ack1, O1,
    output mem_ad, mem_st, mem_X, busy
  );

  modport master (
    output req0, we0, ad0, X0,
    output req1, we1, ad1, X1,
    output mem_O,
    input  ack0, O0, ack1, O1,
    input  mem_ad, mem_st, mem_X, busy
  );
endinterface
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter
// Description : Round-robin arbiter sharing one single-port ram between two
//               req/ack clients. One access in flight; each access takes one
//               IDLE (grant) cycle and one ACCESS cycle, read data is
//               registered back to the winning client together with its ack.
// Ports       : clk   - system clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - ram_arbiter_if.slave (client handshakes, ram bus, busy)
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
  parameter int BUS_WIDTH     = 8,
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  ram_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;

  logic                     r_ack0;
  logic                     r_ack1;
  logic [BUS_WIDTH-1:0]     r_o0;
  logic [BUS_WIDTH-1:0]     r_o1;
  logic [ADDRESS_WIDTH-1:0] r_ad;
  logic [BUS_WIDTH-1:0]     r_x;
  logic                     r_we;
  logic                     r_gnt;   // index of the client being served
  logic                     r_last;  // index of the client served last

  logic                     w_elig0;
  logic                     w_elig1;
  logic                     w_grant;
  logic                     w_gnt_idx;

  // A client in its ack cycle is still holding req for the access that just
  // finished; masking it here prevents a duplicate grant.
  assign w_elig0 = bus.req0 & ~r_ack0;
  assign w_elig1 = bus.req1 & ~r_ack1;

  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_gnt_idx    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_elig0 | w_elig1) begin
          w_grant      = 1'b1;
          // On contention the client that was not served last wins.
          w_gnt_idx    = (w_elig0 & w_elig1) ? ~r_last : w_elig1;
          w_state_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      r_o0   <= '0;
      r_o1   <= '0;
      r_ad   <= '0;
      r_x    <= '0;
      r_we   <= 1'b0;
      r_gnt  <= 1'b0;
      r_last <= 1'b1;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;

      if (w_grant) begin
        r_gnt <= w_gnt_idx;
        r_ad  <= w_gnt_idx ? bus.ad1 : bus.ad0;
        r_x   <= w_gnt_idx ? bus.X1  : bus.X0;
        r_we  <= w_gnt_idx ? bus.we1 : bus.we0;
      end

      // Closing edge of the access: the ram write (if any) happens on this
      // same edge, read data is captured from the combinational ram output.
      if (r_state == ST_ACCESS) begin
        r_last <= r_gnt;
        if (r_gnt) begin
          r_ack1 <= 1'b1;
          if (!r_we) begin
            r_o1 <= bus.mem_O;
          end
        end else begin
          r_ack0 <= 1'b1;
          if (!r_we) begin
            r_o0 <= bus.mem_O;
          end
        end
      end
    end
  end

  assign bus.ack0   = r_ack0;
  assign bus.ack1   = r_ack1;
  assign bus.O0     = r_o0;
  assign bus.O1     = r_o1;
  // Address/data stay on the last latched values outside ACCESS; only the
  // strobe is qualified by state, so it drops with an asynchronous reset.
  assign bus.mem_ad = r_ad;
  assign bus.mem_X  = r_x;
  assign bus.mem_st = (r_state == ST_ACCESS) & r_we;
  assign bus.busy   = (r_state == ST_ACCESS);

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_arbiter
// Description : Self-checking bench for ram_arbiter. A transaction-level
//               model (memory array, round-robin pointer, per-client read
//               data) predicts service order, ack cycle and returned data
//               for each batch of client requests; a monitor compares every
//               ack against the predicted queue. A behavioural ram hangs
//               off the ram side of the interface.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

  typedef struct packed {
    logic       we;
    logic [7:0] ad;
    logic [7:0] x;
  } req_t;

  typedef struct {
    int         client;
    int         cyc;
    logic [7:0] o;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  int   st_cnt;
  int   busy_cnt;

  ram_arbiter_if #(.BUS_WIDTH(8), .ADDRESS_WIDTH(8)) bus ();

  ram_arbiter #(.BUS_WIDTH(8), .ADDRESS_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural single-port ram: combinational read, write on edge with st.
  logic [7:0] ram [256];
  always @(posedge clk) begin
    if (bus.mem_st) ram[bus.mem_ad] <= bus.mem_X;
  end
  assign bus.mem_O = ram[bus.mem_ad];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state.
  logic [7:0] m_mem [256];
  logic [7:0] m_o   [2];
  int         m_last;
  exp_t       sb [$];
  req_t       q0 [$];
  req_t       q1 [$];
  int         at0 [$];
  int         at1 [$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pop_check(input int c, input logic [7:0] o);
    exp_t e;
    check("ack_expected", int'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("ack_client", c, e.client);
      check("ack_cycle", cyc, e.cyc);
      check("ack_data", int'(o), int'(e.o));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_st) st_cnt++;
      if (bus.busy) busy_cnt++;
      check("ack_exclusive", int'(bus.ack0 & bus.ack1), 0);
      if (bus.ack0) pop_check(0, bus.O0);
      if (bus.ack1) pop_check(1, bus.O1);
    end
  end

  task automatic model_reset();
    m_last = 1;
    m_o[0] = 8'h00;
    m_o[1] = 8'h00;
  endtask

  task automatic check_reset_state();
    check("rst_ack0",   int'(bus.ack0),   0);
    check("rst_ack1",   int'(bus.ack1),   0);
    check("rst_busy",   int'(bus.busy),   0);
    check("rst_mem_st", int'(bus.mem_st), 0);
    check("rst_O0",     int'(bus.O0),     0);
    check("rst_O1",     int'(bus.O1),     0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_state();
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic load0(input req_t r);
    bus.req0 = 1'b1; bus.we0 = r.we; bus.ad0 = r.ad; bus.X0 = r.x;
  endtask

  task automatic load1(input req_t r);
    bus.req1 = 1'b1; bus.we1 = r.we; bus.ad1 = r.ad; bus.X1 = r.x;
  endtask

  // Runs all requests queued in q0/q1. The model orders them round-robin
  // (client not served last wins while both have work), first ack two
  // cycles after the request is raised, then +2 cycles when service switches
  // client and +3 when the same client is served again (its ack cycle is
  // not eligible).
  task automatic run_batch(input bit scramble);
    int n0, n1, i0, i1, prev, t, start, total, d0, d1, guard, writes, st0, busy0;
    n0 = q0.size();
    n1 = q1.size();
    total = n0 + n1;
    at0.delete();
    at1.delete();
    @(posedge clk); #1;
    start = cyc;
    i0 = 0; i1 = 0; prev = -1; t = start; writes = 0;
    while (i0 < n0 || i1 < n1) begin
      int   c;
      req_t r;
      exp_t e;
      if (i0 < n0 && i1 < n1) c = (m_last == 0) ? 1 : 0;
      else                    c = (i0 < n0) ? 0 : 1;
      t = (prev < 0) ? start + 2 : t + ((c == prev) ? 3 : 2);
      if (c == 0) begin r = q0[i0]; i0++; at0.push_back(t); end
      else        begin r = q1[i1]; i1++; at1.push_back(t); end
      if (r.we) begin
        e.o = m_o[c];
        m_mem[r.ad] = r.x;
        writes++;
      end else begin
        m_o[c] = m_mem[r.ad];
        e.o = m_o[c];
      end
      e.client = c;
      e.cyc = t;
      sb.push_back(e);
      m_last = c;
      prev = c;
    end
    st0 = st_cnt;
    busy0 = busy_cnt;
    d0 = 0; d1 = 0;
    if (n0 > 0) load0(q0[0]); else bus.req0 = 1'b0;
    if (n1 > 0) load1(q1[0]); else bus.req1 = 1'b0;
    guard = 0;
    while (d0 + d1 < total && guard < 4 * total + 10) begin
      @(negedge clk);
      guard++;
      if (bus.ack0) begin d0++; if (d0 < n0) load0(q0[d0]); else bus.req0 = 1'b0; end
      if (bus.ack1) begin d1++; if (d1 < n1) load1(q1[d1]); else bus.req1 = 1'b0; end
      @(posedge clk); #1;
      // During the predicted ACCESS cycle, disturb the granted client's
      // inputs; the in-flight access must use the values latched at grant.
      if (scramble) begin
        if (bus.req0 && d0 < n0 && cyc == at0[d0] - 1) begin
          bus.ad0 = q0[d0].ad + 8'd1; bus.X0 = ~q0[d0].x; bus.we0 = ~q0[d0].we;
        end
        if (bus.req1 && d1 < n1 && cyc == at1[d1] - 1) begin
          bus.ad1 = q1[d1].ad + 8'd1; bus.X1 = ~q1[d1].x; bus.we1 = ~q1[d1].we;
        end
      end
    end
    check("batch_done", d0 + d1, total);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("batch_writes", st_cnt - st0, writes);
    check("batch_busy", busy_cnt - busy0, total);
    check("sb_drained", sb.size(), 0);
    sb.delete();
    q0.delete();
    q1.delete();
  endtask

  function automatic req_t mk(input logic we, input logic [7:0] ad, input logic [7:0] x);
    req_t r;
    r.we = we; r.ad = ad; r.x = x;
    return r;
  endfunction

  initial begin
    checks = 0; errors = 0; st_cnt = 0; busy_cnt = 0;
    rst_n = 1'b0;
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.ad0 = 8'h00; bus.X0 = 8'h00;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.ad1 = 8'h00; bus.X1 = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_state();
    rst_n = 1'b1;

    // Fill every address through both clients (strict alternation).
    for (int a = 0; a < 256; a++) begin
      if (a < 128) q0.push_back(mk(1'b1, 8'(a), 8'(a * 7 + 3)));
      else         q1.push_back(mk(1'b1, 8'(a), 8'(a * 7 + 3)));
    end
    run_batch(1'b0);

    // Client 0 write then read-back of 0x10.
    q0.push_back(mk(1'b1, 8'h10, 8'hA5));
    q0.push_back(mk(1'b0, 8'h10, 8'h00));
    run_batch(1'b0);

    // Contention straight after reset: client 0 first, client 1 two cycles later.
    q0.push_back(mk(1'b1, 8'h01, 8'h11));
    q1.push_back(mk(1'b1, 8'h02, 8'h22));
    run_batch(1'b0);
    pulse_reset();
    q0.push_back(mk(1'b0, 8'h01, 8'h00));
    q1.push_back(mk(1'b0, 8'h02, 8'h00));
    run_batch(1'b0);

    // Both clients busy continuously for 8 accesses.
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(1'b0, 8'(i + 8'h20), 8'h00));
      q1.push_back(mk(1'b0, 8'(i + 8'h30), 8'h00));
    end
    run_batch(1'b0);

    // Client 1 alone holds req through its ack cycle.
    q1.push_back(mk(1'b0, 8'h40, 8'h00));
    q1.push_back(mk(1'b1, 8'h41, 8'h5A));
    q1.push_back(mk(1'b0, 8'h41, 8'h00));
    run_batch(1'b0);

    // Reset while a write to 0xFF is in ACCESS: strobe drops, no write, no ack.
    @(posedge clk); #1;
    load0(mk(1'b1, 8'hFF, 8'h3C));
    @(posedge clk); #1;
    check("abort_busy", int'(bus.busy), 1);
    check("abort_st_before", int'(bus.mem_st), 1);
    check("abort_mem_ad", int'(bus.mem_ad), 8'hFF);
    bus.req0 = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_st_after", int'(bus.mem_st), 0);
    @(posedge clk); #1;
    check("abort_no_ack0", int'(bus.ack0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    q0.push_back(mk(1'b0, 8'hFF, 8'h00));
    run_batch(1'b0);

    // Address changes from 0x05 to 0x06 during the access.
    q0.push_back(mk(1'b0, 8'h05, 8'h00));
    run_batch(1'b1);

    // Randomized rounds.
    for (int rnd = 0; rnd < 30; rnd++) begin
      int n0, n1;
      n0 = $urandom_range(0, 3);
      n1 = $urandom_range(0, 3);
      if (n0 == 0 && n1 == 0) n0 = 1;
      for (int k = 0; k < n0 + n1; k++) begin
        req_t r;
        r.we = 1'($urandom_range(0, 1));
        r.ad = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
        r.x  = 8'($urandom);
        if (k < n0) q0.push_back(r);
        else        q1.push_back(r);
      end
      run_batch(1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
